// File: rtl/game_pkg.sv
// game_pkg: shared game states and default timing constants.
package game_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } game_state_t;
  localparam int DEF_FRAMES_PER_SEC = 60;
  localparam int DEF_TIME_LIMIT_S = 300;
endpackage

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: m:ss BCD elapsed-time counter, saturating at 9:59, with limit compare.
module bcd_time_counter
  import game_pkg::*;
#(
  parameter int TIME_LIMIT_S = DEF_TIME_LIMIT_S
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] time_min,
  output logic [3:0] time_sec_t,
  output logic [3:0] time_sec_o,
  output logic       at_limit
);
  localparam logic [3:0] LIM_M = 4'(TIME_LIMIT_S / 60);
  localparam logic [3:0] LIM_T = 4'((TIME_LIMIT_S % 60) / 10);
  localparam logic [3:0] LIM_O = 4'(TIME_LIMIT_S % 10);
  logic sat;
  assign sat = time_min == 4'd9 && time_sec_t == 4'd5 && time_sec_o == 4'd9;
  assign at_limit = time_min == LIM_M && time_sec_t == LIM_T && time_sec_o == LIM_O;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      time_min   <= '0;
      time_sec_t <= '0;
      time_sec_o <= '0;
    end else if (clr) begin
      time_min   <= '0;
      time_sec_t <= '0;
      time_sec_o <= '0;
    end else if (inc && !sat) begin
      time_sec_o <= time_sec_o == 4'd9 ? 4'd0 : time_sec_o + 4'd1;
      if (time_sec_o == 4'd9) begin
        time_sec_t <= time_sec_t == 4'd5 ? 4'd0 : time_sec_t + 4'd1;
        if (time_sec_t == 4'd5) time_min <= time_min + 4'd1;
      end
    end
  end
endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: frame tick from vsync, round FSM, frame counter and BCD play timer.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
  parameter int TIME_LIMIT_S = DEF_TIME_LIMIT_S
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vs,
  input  logic       start,
  input  logic       win,
  input  logic       lose,
  output logic       play_en,
  output logic [1:0] game_state,
  output logic [3:0] time_min,
  output logic [3:0] time_sec_t,
  output logic [3:0] time_sec_o,
  output logic       frame_tick,
  output logic       timeout
);
  if (TIME_LIMIT_S < 1 || TIME_LIMIT_S > 599 || FRAMES_PER_SEC < 1) begin : g_bad_param
    $error("game_state_ctrl: TIME_LIMIT_S must be 1..599 and FRAMES_PER_SEC >= 1");
  end
  localparam int FC_W = FRAMES_PER_SEC > 1 ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_SEC - 1);
  game_state_t state, state_next;
  logic vs_s1, vs_s2, vs_q, start_q, start_arm, start_rise;
  logic timeout_next, wrap, stay_play, at_limit;
  logic [FC_W-1:0] fcnt;
  // start_arm blocks a start level already high when reset releases
  assign start_rise = start && !start_q && start_arm;
  assign wrap = fcnt == FC_LAST;
  assign stay_play = state == PLAY && state_next == PLAY;
  assign game_state = state;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_s1      <= 1'b1;
      vs_s2      <= 1'b1;
      vs_q       <= 1'b1;
      frame_tick <= 1'b0;
      start_q    <= 1'b0;
      start_arm  <= 1'b0;
    end else begin
      vs_s1      <= vs;
      vs_s2      <= vs_s1;
      vs_q       <= vs_s2;
      frame_tick <= vs_q && !vs_s2;
      start_q    <= start;
      start_arm  <= start_arm || !start;
    end
  end
  always_comb begin
    state_next = state;
    timeout_next = 1'b0;
    case (state)
      IDLE: state_next = start_rise ? PLAY : IDLE;
      PLAY: begin
        state_next = lose ? LOST : win ? WON : at_limit ? LOST : PLAY;
        timeout_next = !lose && !win && at_limit;
      end
      WON, LOST: state_next = start_rise ? IDLE : state;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      play_en <= 1'b0;
      timeout <= 1'b0;
      fcnt    <= '0;
    end else begin
      state   <= state_next;
      play_en <= state_next == PLAY;
      timeout <= timeout_next;
      fcnt    <= state_next == IDLE ? '0 : stay_play && frame_tick ? (wrap ? '0 : fcnt + 1'b1) : fcnt;
    end
  end
  bcd_time_counter #(.TIME_LIMIT_S(TIME_LIMIT_S)) u_time (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .clr       (state_next == IDLE),
    .inc       (stay_play && frame_tick && wrap),
    .time_min  (time_min),
    .time_sec_t(time_sec_t),
    .time_sec_o(time_sec_o),
    .at_limit  (at_limit)
  );
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: randomized scoreboard bench for two game_state_ctrl configurations.
module tb_game_state_ctrl;
  typedef struct {
    logic [16:0] v;
    int c;
  } ev_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic vs_a[2], start_a[2], win_a[2], lose_a[2];
  logic pe0, pe1, ft0, ft1, to0, to1;
  logic [1:0] gs0, gs1;
  logic [3:0] m0, t0, o0, m1, t1, o1;
  logic [16:0] ov[2];
  logic [16:0] prev[2];
  ev_t sb[2][$];
  int checks = 0, errors = 0, cyc = 0;
  int fps[2] = '{2, 1};
  int lim[2] = '{5, 599};
  int st[2], sec[2], fr[2];
  bit mon_on = 1'b0;
  game_state_ctrl #(.FRAMES_PER_SEC(2), .TIME_LIMIT_S(5)) dut (
    .Clk(clk), .Reset_n(rst_n), .vs(vs_a[0]), .start(start_a[0]), .win(win_a[0]), .lose(lose_a[0]),
    .play_en(pe0), .game_state(gs0), .time_min(m0), .time_sec_t(t0), .time_sec_o(o0),
    .frame_tick(ft0), .timeout(to0)
  );
  game_state_ctrl #(.FRAMES_PER_SEC(1), .TIME_LIMIT_S(599)) dut2 (
    .Clk(clk), .Reset_n(rst_n), .vs(vs_a[1]), .start(start_a[1]), .win(win_a[1]), .lose(lose_a[1]),
    .play_en(pe1), .game_state(gs1), .time_min(m1), .time_sec_t(t1), .time_sec_o(o1),
    .frame_tick(ft1), .timeout(to1)
  );
  assign ov[0] = {gs0, pe0, m0, t0, o0, ft0, to0};
  assign ov[1] = {gs1, pe1, m1, t1, o1, ft1, to1};
  always @(posedge clk) cyc <= cyc + 1;
  // expected output vector from a game state code (0..3) and elapsed seconds
  function automatic logic [16:0] pk(int s, int t, bit tk, bit tout);
    return {s[1:0], s == 1, 4'(t / 60), 4'((t % 60) / 10), 4'(t % 10), tk, tout};
  endfunction
  function automatic logic [16:0] mv(int d);
    return pk(st[d], sec[d], 1'b0, 1'b0);
  endfunction
  task automatic push(int d, logic [16:0] v, int c);
    ev_t e;
    e.v = v;
    e.c = c;
    sb[d].push_back(e);
  endtask
  task automatic frame(int d, bit wf);
    int f;
    @(negedge clk);
    f = cyc;
    vs_a[d] = 1'b0;
    push(d, pk(st[d], sec[d], 1'b1, 1'b0), f + 3);
    if (st[d] == 1) begin
      fr[d]++;
      if (fr[d] == fps[d]) begin
        fr[d] = 0;
        if (sec[d] < 599) sec[d]++;
      end
    end
    push(d, mv(d), f + 4);
    if (st[d] == 1 && wf) begin
      st[d] = 2;
      push(d, mv(d), f + 5);
    end else if (st[d] == 1 && sec[d] == lim[d]) begin
      st[d] = 3;
      push(d, pk(3, sec[d], 1'b0, 1'b1), f + 5);
      push(d, mv(d), f + 6);
    end
    repeat (4) @(negedge clk);
    win_a[d] = wf;
    @(negedge clk);
    win_a[d] = 1'b0;
    vs_a[d] = 1'b1;
    repeat (5) @(negedge clk);
  endtask
  task automatic start_pulse(int d);
    int k;
    @(negedge clk);
    k = cyc;
    start_a[d] = 1'b1;
    if (st[d] == 0) begin
      st[d] = 1;
      push(d, mv(d), k + 1);
    end else if (st[d] >= 2) begin
      st[d] = 0;
      sec[d] = 0;
      fr[d] = 0;
      push(d, mv(d), k + 1);
    end
    repeat (3) @(negedge clk);
    start_a[d] = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic wl(int d, bit w, bit l);
    int k;
    @(negedge clk);
    k = cyc;
    win_a[d] = w;
    lose_a[d] = l;
    if (st[d] == 1 && (w || l)) begin
      st[d] = l ? 3 : 2;
      push(d, mv(d), k + 1);
    end
    @(negedge clk);
    win_a[d] = 1'b0;
    lose_a[d] = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    ev_t e;
    wait (mon_on);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ov[d] !== prev[d]) begin
          checks++;
          if (sb[d].size() == 0) begin
            errors++;
            $display("FAIL dut%0d unexpected change: got %h at cycle %0d, required no change", d, ov[d], cyc);
          end else begin
            e = sb[d].pop_front();
            if (ov[d] !== e.v || (e.c >= 0 && e.c != cyc)) begin
              errors++;
              $display("FAIL dut%0d event: got %h at cycle %0d, required %h at cycle %0d", d, ov[d], cyc, e.v, e.c);
            end
          end
          prev[d] = ov[d];
        end
      end
    end
  end
  initial begin
    int k;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vs_a[d] = 1'b1;
      start_a[d] = 1'b0;
      win_a[d] = 1'b0;
      lose_a[d] = 1'b0;
      st[d] = 0;
      sec[d] = 0;
      fr[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ov[d] !== pk(0, 0, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL dut%0d reset: got %h, required %h", d, ov[d], pk(0, 0, 1'b0, 1'b0));
      end
      prev[d] = pk(0, 0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;
    repeat (2) @(negedge clk);
    start_pulse(0);
    repeat (4) frame(0, 1'b0);
    repeat (8) frame(0, 1'b0);
    start_pulse(0);
    start_pulse(0);
    wl(0, 1'b1, 1'b1);
    start_pulse(0);
    start_pulse(0);
    repeat (9) frame(0, 1'b0);
    frame(0, 1'b1);
    start_pulse(0);
    @(negedge clk);
    win_a[0] = 1'b1;
    repeat (3) @(negedge clk);
    k = cyc;
    start_a[0] = 1'b1;
    st[0] = 1;
    push(0, mv(0), k + 1);
    st[0] = 2;
    push(0, mv(0), k + 2);
    repeat (3) @(negedge clk);
    start_a[0] = 1'b0;
    win_a[0] = 1'b0;
    repeat (3) @(negedge clk);
    start_pulse(0);
    start_pulse(0);
    start_pulse(0);
    repeat (6) frame(0, 1'b0);
    @(negedge clk);
    start_a[0] = 1'b1;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (mv(d) !== pk(0, 0, 1'b0, 1'b0)) push(d, pk(0, 0, 1'b0, 1'b0), -1);
      st[d] = 0;
      sec[d] = 0;
      fr[d] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    start_a[0] = 1'b0;
    repeat (2) @(negedge clk);
    start_pulse(0);
    wl(0, 1'b0, 1'b1);
    repeat (120) begin
      k = int'($urandom_range(0, 9));
      if (k < 6) frame(0, $urandom_range(0, 7) == 0);
      else if (k < 8) start_pulse(0);
      else wl(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    start_pulse(1);
    repeat (600) frame(1, 1'b0);
    repeat (10) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (sb[d].size() != 0) begin
        errors++;
        $display("FAIL dut%0d pending events: got %0d left, required 0", d, sb[d].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 The block SHALL have parameter FRAMES_PER_SEC, default 60, giving the number of frames that make up one second of game time.
REQ-002 The block SHALL have parameter TIME_LIMIT_S, default 300, giving the play time in seconds after which the round is lost; the legal range is 1..599, and any other value SHALL cause an elaboration error.
REQ-003 Clk  input  1  pixel clock (VGA_Clk, 25 MHz); the block has one clock, and this is it.
REQ-004 Reset_n  input  1  asynchronous active-low reset.
REQ-005 vs  input  1  raw active-low vertical sync from vga_controller; asynchronous to Clk.
REQ-006 start  input  1  level start/restart request from key_select.
REQ-007 win  input  1  level, round-won indication.
REQ-008 lose  input  1  level, round-lost indication.
REQ-009 play_en  output  1  high only in PLAY; gates character/board movement.
REQ-010 game_state  output  2  0=IDLE, 1=PLAY, 2=WON, 3=LOST.
REQ-011 time_min / time_sec_t / time_sec_o  output  4 each  elapsed time as BCD digits (m:s s) for the HexDriver blocks.
REQ-012 frame_tick  output  1  one-Clk pulse per frame.
REQ-013 timeout  output  1  one-Clk pulse when the time limit ends the round.

Function
REQ-014 vs SHALL pass through a 2-flop synchronizer, followed by a registered falling-edge detector.
REQ-015 frame_tick SHALL be high for exactly one Clk cycle per vs falling edge, at the 3rd rising Clk edge after the falling edge.
REQ-016 start SHALL be edge-detected with a registered previous value; only a 0->1 transition (start_rise) SHALL act, and a held level SHALL never retrigger.
REQ-017 IDLE: play_en=0, timer held at 0:00, frame counter held at 0; on start_rise go to PLAY.
REQ-018 PLAY: play_en=1; the frame counter (width clog2(FRAMES_PER_SEC)) SHALL increment on each frame_tick.
REQ-019 In PLAY, when the frame counter is at FRAMES_PER_SEC-1, the next frame_tick SHALL wrap it to 0 and increment the BCD time in the same cycle.
REQ-020 BCD rules: sec_o 9->0 carries into sec_t; sec_t 5->0 carries into min; the timer SHALL saturate at 9:59 and never wrap.
REQ-021 The PLAY exit, evaluated every cycle, SHALL follow this priority: lose -> LOST; else win -> WON; else elapsed==TIME_LIMIT_S -> LOST with timeout=1 for that one cycle.
REQ-022 If win and the limit are reached in the same cycle, the state SHALL go to WON and timeout SHALL not pulse.
REQ-023 start_rise in PLAY SHALL be ignored.
REQ-024 WON/LOST: play_en=0, timer frozen at its final value; on start_rise go to IDLE, which clears the timer.
REQ-025 win/lose asserted outside PLAY SHALL be ignored.
REQ-026 All outputs SHALL be registered; a state change SHALL be visible on game_state/play_en one Clk edge after its cause is sampled.

Reset
REQ-027 While Reset_n=0, the block SHALL be asynchronously forced to: state=IDLE, play_en=0, timer 0:00, frame counter 0, synchronizer flops 1, edge registers 1 (vs) and 0 (start), frame_tick=0, timeout=0.
REQ-028 Reset mid-round SHALL abandon the round with no timeout pulse.
REQ-029 After release, a start already held high SHALL not count as start_rise until it drops and rises again.

Structure
REQ-030 Shared package game_pkg SHALL hold the game_state_t enum (IDLE, PLAY, WON, LOST) and the constants DEF_FRAMES_PER_SEC=60 and DEF_TIME_LIMIT_S=300.
REQ-031 Sub-module bcd_time_counter SHALL hold the 3-digit BCD counter: inputs clr and inc; outputs the three digits and at_limit, with the limit pre-converted to BCD at elaboration.
REQ-032 The top level SHALL hold the synchronizer, the edge detectors, the frame counter and the FSM.

Verification (FRAMES_PER_SEC=2, TIME_LIMIT_S=5 unless stated)
REQ-033 Reset release, then start pulse, then 4 vs falling edges -> game_state=1, play_en=1, time 0:02, frame_tick pulsed 4 times, each 1 cycle wide, each 3 Clk after its edge.
REQ-034 In PLAY, 10 frames -> game_state=3 at 0:05, timeout exactly one cycle high, timer frozen at 0:05 under further frames.
REQ-035 In PLAY, win and lose asserted in the same cycle -> LOST, timeout=0; start pulse -> IDLE, 0:00; second start pulse -> PLAY.
REQ-036 TIME_LIMIT_S=599, FRAMES_PER_SEC=1: after 59 ticks -> 0:59; next tick -> 1:00; at 9:59 -> LOST with timeout=1.
REQ-037 Reset_n pulsed low mid-round at 0:03 -> immediately IDLE, 0:00, play_en=0, timeout never high; start held high across release -> stays IDLE.
REQ-038 win asserted in IDLE, then start -> PLAY, not WON; win held high through the transition -> WON on the following cycle.
